// File: rtl/arch_defs_pkg.sv
// arch_defs_pkg: shared state encoding for the self-test sequencer
package arch_defs_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_FLUSH, ST_RUN, ST_CHECK, ST_DONE} selftest_state_t;
endpackage

// File: rtl/selftest_loader.sv
// selftest_loader: image ROM address counter with the RAM write trailing one cycle behind
module selftest_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int IMG_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_img_data,
  output logic [ADDR_WIDTH-1:0] o_img_addr,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  output logic                  o_last
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_DEPTH - 1);
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic                  r_we;
  assign o_last      = i_en && r_addr == LAST_ADDR;
  assign o_img_addr  = r_addr;
  assign o_ram_we    = r_we;
  assign o_ram_addr  = r_ram_addr;
  // ROM data arrives the cycle after its address, lined up with the registered write address
  assign o_ram_wdata = r_we ? i_img_data : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_addr     <= '0;
      r_ram_addr <= '0;
      r_we       <= 1'b0;
    end else begin
      r_addr <= i_clr ? '0 : (i_en && !o_last) ? r_addr + 1'b1 : r_addr;
      r_we   <= i_en;
      if (i_en) r_ram_addr <= r_addr;
    end
endmodule

// File: rtl/selftest_sequencer.sv
// selftest_sequencer: loads a program image, runs the CPU to HLT or timeout, checks probes
// Optional SELFTEST_MASK_EN adds check_en to exclude channels from the comparison.
module selftest_sequencer
  import arch_defs_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int IMG_DEPTH  = 16,
  parameter int TIMEOUT_W  = 8,
  parameter int NUM_CHECKS = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             cpu_hold,
  output logic [ADDR_WIDTH-1:0]            img_addr,
  input  logic [DATA_WIDTH-1:0]            img_data,
  output logic                             ram_we,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  input  logic                             cpu_halt,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0] probe_data,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0] expect_data,
`ifdef SELFTEST_MASK_EN
  input  logic [NUM_CHECKS-1:0]            check_en,
`endif
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic                             timed_out,
  output logic [NUM_CHECKS-1:0]            fail_mask,
  output logic [TIMEOUT_W-1:0]             cycle_count
);
  localparam logic [TIMEOUT_W-1:0] LIMIT = '1;
  selftest_state_t       r_state;
  selftest_state_t       w_next;
  logic                  r_pass;
  logic                  r_timed_out;
  logic [NUM_CHECKS-1:0] r_fail_mask;
  logic [TIMEOUT_W-1:0]  r_cycles;
  logic                  w_start;
  logic                  w_last;
  logic [NUM_CHECKS-1:0] w_en;
  logic [NUM_CHECKS-1:0] w_mismatch;
`ifdef SELFTEST_MASK_EN
  assign w_en = check_en;
`else
  assign w_en = '1;
`endif
  for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_cmp
    assign w_mismatch[i] = probe_data[i*DATA_WIDTH +: DATA_WIDTH] != expect_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  selftest_loader #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .IMG_DEPTH (IMG_DEPTH)
  ) u_loader (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_start),
    .i_en       (r_state == ST_LOAD),
    .i_img_data (img_data),
    .o_img_addr (img_addr),
    .o_ram_we   (ram_we),
    .o_ram_addr (ram_addr),
    .o_ram_wdata(ram_wdata),
    .o_last     (w_last)
  );
  assign w_start = start && (r_state == ST_IDLE || r_state == ST_DONE);
  // halt is tested before the limit so a halt on the final cycle still gets checked
  assign w_next = w_start                ? ST_LOAD :
                  r_state == ST_LOAD     ? (w_last ? ST_FLUSH : ST_LOAD) :
                  r_state == ST_FLUSH    ? ST_RUN :
                  r_state == ST_RUN      ? (cpu_halt ? ST_CHECK : r_cycles == LIMIT ? ST_DONE : ST_RUN) :
                  r_state == ST_CHECK    ? ST_DONE : r_state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_pass      <= 1'b0;
      r_timed_out <= 1'b0;
      r_fail_mask <= '0;
      r_cycles    <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_pass      <= 1'b0;
        r_timed_out <= 1'b0;
        r_fail_mask <= '0;
        r_cycles    <= '0;
      end else if (r_state == ST_RUN && !cpu_halt) begin
        if (r_cycles == LIMIT) r_timed_out <= 1'b1;
        else r_cycles <= r_cycles + 1'b1;
      end else if (r_state == ST_CHECK) begin
        r_fail_mask <= w_mismatch & w_en;
        r_pass      <= ~|(w_mismatch & w_en);
      end
    end
  // hold stays released through CHECK so the halted CPU keeps its probed registers
  assign cpu_hold    = !(r_state == ST_RUN || r_state == ST_CHECK);
  assign busy        = r_state == ST_LOAD || r_state == ST_FLUSH || r_state == ST_RUN || r_state == ST_CHECK;
  assign done        = r_state == ST_DONE;
  assign pass        = r_pass;
  assign timed_out   = r_timed_out;
  assign fail_mask   = r_fail_mask;
  assign cycle_count = r_cycles;
endmodule

// File: tb/tb_selftest_sequencer.sv
// tb_selftest_sequencer: table-driven and randomized checks of load, run, check and abort behaviour
module tb_selftest_sequencer;
  localparam int D   = 16;
  localparam int LIM = 15;
  typedef struct {
    int         h;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [1:0] en;
    bit         pulse;
    logic       p;
    logic       to;
    logic [1:0] m;
    logic [3:0] cnt;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cpu_halt = 1'b0;
  logic        cpu_hold, ram_we, busy, done, pass, timed_out;
  logic [3:0]  img_addr, ram_addr, cycle_count;
  logic [7:0]  img_data, ram_wdata;
  logic [1:0]  fail_mask;
  logic [1:0]  check_en = 2'b11;
  logic [15:0] probe_data, expect_data;
  logic [7:0]  rom [16];
  logic [7:0]  ram [16];
  int          n_chk = 0;
  int          n_fail = 0;
  vec_t        tbl[$];
  always #5 clk = ~clk;
  always @(posedge clk) img_data <= rom[img_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;
  // channel 0 is register B (loaded by LDB 0xE), channel 1 reads back the HLT word
  assign probe_data = {ram[1], ram[14]};
  selftest_sequencer #(.TIMEOUT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cpu_hold   (cpu_hold),
    .img_addr   (img_addr),
    .img_data   (img_data),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .cpu_halt   (cpu_halt),
    .probe_data (probe_data),
    .expect_data(expect_data),
`ifdef SELFTEST_MASK_EN
    .check_en   (check_en),
`endif
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timed_out  (timed_out),
    .fail_mask  (fail_mask),
    .cycle_count(cycle_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_reset();
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_fail_mask", fail_mask, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_img_addr", img_addr, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
  endtask
  // cycle c counts from 1 in the cycle after the edge that samples start
  task automatic run(input int h, input logic [7:0] e0, input logic [7:0] e1, input bit pulse,
                     input logic p, input logic to, input logic [1:0] m, input logic [3:0] cnt);
    int done_c;
    int bad;
    done_c = (h > LIM) ? D + 18 : D + 4 + h;
    expect_data = {e1, e0};
    cpu_halt = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    for (int c = 1; c <= done_c + 1; c++) begin
      chk("busy", busy, c < done_c);
      chk("done", done, c >= done_c);
      chk("cpu_hold", cpu_hold, !(c >= D + 2 && c < done_c));
      chk("ram_we", ram_we, c >= 2 && c <= D + 1);
      if (c >= 2 && c <= D + 1) begin
        chk("ram_addr", ram_addr, c - 2);
        chk("ram_wdata", ram_wdata, rom[c-2]);
      end
      if (c <= D) chk("img_addr", img_addr, c - 1);
      chk("cycle_count", cycle_count, c < D + 2 ? 0 : c <= D + 2 + int'(cnt) ? c - D - 2 : cnt);
      chk("pass", pass, c >= done_c && p);
      chk("timed_out", timed_out, c >= done_c && to);
      chk("fail_mask", fail_mask, c >= done_c ? m : 2'b00);
      cpu_halt = c >= D + 2 + h;
      start = pulse && c == D + 4;
      @(posedge clk);
      #1;
    end
    cpu_halt = 1'b0;
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) if (ram[i] !== rom[i]) bad++;
    chk("ram_image", bad, 0);
  endtask
  initial begin
    logic [7:0] e0, e1;
    logic [1:0] m;
    logic       to;
    int         h;
    for (int i = 0; i < 16; i++) rom[i] = 8'(i * 8'h13 + 8'h20);
    rom[0]  = 8'h1E;
    rom[1]  = 8'hF0;
    rom[14] = 8'h11;
    tbl.push_back('{3,  8'h11, 8'hF0, 2'b11, 0, 1, 0, 2'b00, 4'd3});
    tbl.push_back('{3,  8'h12, 8'hF0, 2'b11, 0, 0, 0, 2'b01, 4'd3});
    tbl.push_back('{99, 8'h11, 8'hF0, 2'b11, 0, 0, 1, 2'b00, 4'd15});
    tbl.push_back('{15, 8'h11, 8'hF0, 2'b11, 0, 1, 0, 2'b00, 4'd15});
    tbl.push_back('{0,  8'h11, 8'h00, 2'b11, 0, 0, 0, 2'b10, 4'd0});
    tbl.push_back('{7,  8'h11, 8'hF0, 2'b11, 1, 1, 0, 2'b00, 4'd7});
    tbl.push_back('{99, 8'h00, 8'h00, 2'b11, 0, 0, 1, 2'b00, 4'd15});
`ifdef SELFTEST_MASK_EN
    tbl.push_back('{5,  8'h22, 8'h33, 2'b10, 0, 0, 0, 2'b10, 4'd5});
    tbl.push_back('{5,  8'h22, 8'h33, 2'b00, 0, 1, 0, 2'b00, 4'd5});
`endif
    repeat (3) @(posedge clk);
    #1 chk_reset();
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1 chk_reset();
    foreach (tbl[i]) begin
      check_en = tbl[i].en;
      run(tbl[i].h, tbl[i].e0, tbl[i].e1, tbl[i].pulse, tbl[i].p, tbl[i].to, tbl[i].m, tbl[i].cnt);
    end
    check_en = 2'b11;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    for (int i = 0; i < 20 && img_addr != 4'd5; i++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_addr5", img_addr, 5);
    #2 reset = 1'b0;
    #1 chk_reset();
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1 chk_reset();
    run(4, 8'h11, 8'hF0, 0, 1, 0, 2'b00, 4'd4);
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      h  = $urandom_range(0, 19);
      e0 = $urandom_range(0, 1) ? rom[14] : rom[14] ^ 8'($urandom_range(1, 255));
      e1 = $urandom_range(0, 1) ? rom[1] : rom[1] ^ 8'($urandom_range(1, 255));
`ifdef SELFTEST_MASK_EN
      check_en = 2'($urandom);
`endif
      to = h > LIM;
      m  = to ? 2'b00 : {e1 != rom[1], e0 != rom[14]} & check_en;
      run(h, e0, e1, 0, !to && m == 2'b00, to, m, to ? 4'(LIM) : 4'(h));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
